// File: rtl/abp_pkg.sv
// Shared Alternating Bit Protocol definitions: receiver state encoding,
// header bit position, statistics counter width and a saturating increment.
package abp_pkg;

   typedef enum logic [2:0] {
      ABP_ST_IDLE,
      ABP_ST_RECV,
      ABP_ST_DRAIN,
      ABP_ST_CHECK,
      ABP_ST_DELIVER,
      ABP_ST_ACK
   } abp_rx_state_t;

   localparam int ABP_HDR_SEQ_BIT = 0;
   localparam int ABP_STAT_W      = 16;

   function automatic logic [ABP_STAT_W-1:0] abp_sat_inc(input logic [ABP_STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/abp_payload_assembler.sv
// Byte-indexed payload register file plus frame length counter.
// clear restarts the count at 1 (header beat); wr_en stores a byte and counts it.
module abp_payload_assembler #(
   parameter int PAYLOAD_BYTES = 8,
   parameter int CNT_W         = 7
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       clear,
   input  logic                       wr_en,
   input  logic [CNT_W-1:0]           wr_index,
   input  logic [7:0]                 wr_data,
   output logic [CNT_W-1:0]           count,
   output logic [8*PAYLOAD_BYTES-1:0] payload
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         count_reg <= '0;
      else if (clear)
         count_reg <= CNT_W'(1);
      else if (wr_en)
         count_reg <= count_reg + 1'b1;
   end

   assign count = count_reg;

   // Indices at or beyond PAYLOAD_BYTES match no slot, so excess bytes are never stored.
   for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_byte
      logic [7:0] byte_reg;

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn)
            byte_reg <= '0;
         else if (wr_en && (wr_index == CNT_W'(gi)))
            byte_reg <= wr_data;
      end

      assign payload[8*gi +: 8] = byte_reg;
   end

endmodule

// File: rtl/abp_packet_receiver.sv
// Alternating Bit Protocol receiver: frames AXI-Stream bytes, checks the sequence
// bit, delivers new payloads and acknowledges every valid frame. Stats: ABP_RX_STATS_EN.
module abp_packet_receiver
   import abp_pkg::*;
#(
   parameter int PAYLOAD_BYTES = 8,
   parameter int MAX_PKT_BYTES = 64
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   input  logic [7:0]                 s_axis_tdata,
   output logic                       m_value_valid,
   input  logic                       m_value_ready,
   output logic [8*PAYLOAD_BYTES-1:0] m_value_data,
   output logic                       ack_valid,
   input  logic                       ack_ready,
   output logic                       ack_bit,
   output logic                       expected_bit,
   output logic                       busy,
   output logic [ABP_STAT_W-1:0]      stat_good,
   output logic [ABP_STAT_W-1:0]      stat_dup,
   output logic [ABP_STAT_W-1:0]      stat_drop
);

   localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);
   localparam int PW    = 8 * PAYLOAD_BYTES;

   abp_rx_state_t state_reg, state_next;
   logic          ready_en_reg;
   logic          value_valid_reg, value_valid_next;
   logic          ack_valid_reg, ack_valid_next;
   logic          ack_bit_reg, ack_bit_next;
   logic          expected_bit_reg, expected_bit_next;
   logic          hdr_bit_reg, hdr_bit_next;
   logic [PW-1:0] value_data_reg, value_data_next;

   logic             asm_clear, asm_wr_en;
   logic [CNT_W-1:0] asm_count;
   logic [PW-1:0]    asm_payload;
   logic             beat, len_ok, is_new;

   abp_payload_assembler #(
      .PAYLOAD_BYTES(PAYLOAD_BYTES),
      .CNT_W        (CNT_W)
   ) u_assembler (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clear   (asm_clear),
      .wr_en   (asm_wr_en),
      .wr_index(asm_count - 1'b1),
      .wr_data (s_axis_tdata),
      .count   (asm_count),
      .payload (asm_payload)
   );

   // ready_en_reg keeps tready low for the whole reset cycle.
   assign s_axis_tready = ready_en_reg &&
                          (state_reg == ABP_ST_IDLE || state_reg == ABP_ST_RECV ||
                           state_reg == ABP_ST_DRAIN);
   assign beat   = s_axis_tvalid && s_axis_tready;
   assign len_ok = (asm_count == CNT_W'(PAYLOAD_BYTES + 1));
   assign is_new = (hdr_bit_reg == expected_bit_reg);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg        <= ABP_ST_IDLE;
         ready_en_reg     <= 1'b0;
         value_valid_reg  <= 1'b0;
         ack_valid_reg    <= 1'b0;
         ack_bit_reg      <= 1'b0;
         expected_bit_reg <= 1'b0;
         hdr_bit_reg      <= 1'b0;
         value_data_reg   <= '0;
      end else begin
         state_reg        <= state_next;
         ready_en_reg     <= 1'b1;
         value_valid_reg  <= value_valid_next;
         ack_valid_reg    <= ack_valid_next;
         ack_bit_reg      <= ack_bit_next;
         expected_bit_reg <= expected_bit_next;
         hdr_bit_reg      <= hdr_bit_next;
         value_data_reg   <= value_data_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      value_valid_next  = value_valid_reg;
      ack_valid_next    = ack_valid_reg;
      ack_bit_next      = ack_bit_reg;
      expected_bit_next = expected_bit_reg;
      hdr_bit_next      = hdr_bit_reg;
      value_data_next   = value_data_reg;
      asm_clear         = 1'b0;
      asm_wr_en         = 1'b0;
      case (state_reg)
         ABP_ST_IDLE: begin
            if (beat) begin
               hdr_bit_next = s_axis_tdata[ABP_HDR_SEQ_BIT];
               asm_clear    = 1'b1;
               state_next   = s_axis_tlast ? ABP_ST_CHECK : ABP_ST_RECV;
            end
         end
         ABP_ST_RECV: begin
            if (beat) begin
               asm_wr_en = 1'b1;
               if (s_axis_tlast)
                  state_next = ABP_ST_CHECK;
               else if (asm_count == CNT_W'(MAX_PKT_BYTES - 1))
                  state_next = ABP_ST_DRAIN;
            end
         end
         ABP_ST_DRAIN: begin
            if (beat && s_axis_tlast)
               state_next = ABP_ST_IDLE;
         end
         ABP_ST_CHECK: begin
            if (!len_ok) begin
               state_next = ABP_ST_IDLE;
            end else if (is_new) begin
               value_data_next   = asm_payload;
               value_valid_next  = 1'b1;
               ack_valid_next    = 1'b1;
               ack_bit_next      = hdr_bit_reg;
               expected_bit_next = ~expected_bit_reg;
               state_next        = ABP_ST_DELIVER;
            end else begin
               ack_valid_next = 1'b1;
               ack_bit_next   = hdr_bit_reg;
               state_next     = ABP_ST_ACK;
            end
         end
         ABP_ST_DELIVER: begin
            if (m_value_ready)
               value_valid_next = 1'b0;
            if (ack_ready)
               ack_valid_next = 1'b0;
            if (!value_valid_next && !ack_valid_next)
               state_next = ABP_ST_IDLE;
         end
         ABP_ST_ACK: begin
            if (ack_ready) begin
               ack_valid_next = 1'b0;
               state_next     = ABP_ST_IDLE;
            end
         end
         default: state_next = ABP_ST_IDLE;
      endcase
   end

   assign m_value_valid = value_valid_reg;
   assign m_value_data  = value_data_reg;
   assign ack_valid     = ack_valid_reg;
   assign ack_bit       = ack_bit_reg;
   assign expected_bit  = expected_bit_reg;
   assign busy          = (state_reg != ABP_ST_IDLE);

`ifdef ABP_RX_STATS_EN
   logic [ABP_STAT_W-1:0] stat_good_reg, stat_dup_reg, stat_drop_reg;
   logic                  good_inc, dup_inc, drop_inc;

   assign good_inc = (state_reg == ABP_ST_CHECK) && len_ok && is_new;
   assign dup_inc  = (state_reg == ABP_ST_CHECK) && len_ok && !is_new;
   assign drop_inc = ((state_reg == ABP_ST_CHECK) && !len_ok) ||
                     ((state_reg == ABP_ST_DRAIN) && beat && s_axis_tlast);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stat_good_reg <= '0;
         stat_dup_reg  <= '0;
         stat_drop_reg <= '0;
      end else begin
         if (good_inc) stat_good_reg <= abp_sat_inc(stat_good_reg);
         if (dup_inc)  stat_dup_reg  <= abp_sat_inc(stat_dup_reg);
         if (drop_inc) stat_drop_reg <= abp_sat_inc(stat_drop_reg);
      end
   end

   assign stat_good = stat_good_reg;
   assign stat_dup  = stat_dup_reg;
   assign stat_drop = stat_drop_reg;
`else
   assign stat_good = '0;
   assign stat_dup  = '0;
   assign stat_drop = '0;
`endif

endmodule
